// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold/flush controller for load-use, multi-cycle EX ops and MEM bus waits
module pipe_ctrl #(
   parameter int         MD_CYCLES   = 4,
   parameter int         MEM_TIMEOUT = 16,
   parameter logic [2:0] LOAD_NOPE   = 3'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] rs1_addr_id,
   input  logic       rs1_use_id,
   input  logic [4:0] rs2_addr_id,
   input  logic       rs2_use_id,
   input  logic [2:0] load_code_ex,
   input  logic [4:0] addr_rd_ex,
   input  logic       reg_wr_en_ex,
   input  logic       md_start_ex,
   input  logic       jump_en_ex,
   input  logic       mem_req_mem,
   input  logic       mem_ack_mem,
   output logic       hold_pc_n,
   output logic       hold_if_id_n,
   output logic       hold_id_ex_n,
   output logic       hold_ex_mem_n,
   output logic       hold_mem_wb_n,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic       flush_ex_mem,
   output logic       md_done,
   output logic       bus_err
);
   localparam int MW = ($clog2(MD_CYCLES) < 1) ? 1 : $clog2(MD_CYCLES);
   localparam int WW = ($clog2(MEM_TIMEOUT) < 1) ? 1 : $clog2(MEM_TIMEOUT);
   typedef enum logic {RUN, MD_BUSY} state_t;
   state_t        state, state_nx;
   logic [MW-1:0] md_cnt, md_cnt_nx;
   logic [WW-1:0] wait_cnt;
   logic          mem_wait, timeout, mem_stall, md_stall, load_use;
   assign mem_wait  = mem_req_mem && !mem_ack_mem;
   assign timeout   = mem_wait && (wait_cnt == WW'(MEM_TIMEOUT - 1));
   assign mem_stall = mem_wait && !timeout;
   assign md_stall  = (state == RUN) ? md_start_ex : (md_cnt != '0);
   assign load_use  = (load_code_ex != LOAD_NOPE) && reg_wr_en_ex && (addr_rd_ex != 5'd0) &&
                      ((rs1_use_id && rs1_addr_id == addr_rd_ex) || (rs2_use_id && rs2_addr_id == addr_rd_ex));
   always_comb begin
      state_nx  = state;
      md_cnt_nx = md_cnt;
      if (state == RUN) begin
         if (md_start_ex && !mem_stall) begin
            state_nx  = MD_BUSY;
            md_cnt_nx = MW'(MD_CYCLES - 2);
         end
      end else begin
         md_cnt_nx = (md_cnt != '0) ? md_cnt - MW'(1) : md_cnt;
         state_nx  = (md_cnt == '0 && !mem_stall) ? RUN : MD_BUSY;
      end
   end
   always_comb begin
      hold_pc_n     = 1'b1;
      hold_if_id_n  = 1'b1;
      hold_id_ex_n  = 1'b1;
      hold_ex_mem_n = 1'b1;
      hold_mem_wb_n = 1'b1;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      flush_ex_mem  = 1'b0;
      md_done       = 1'b0;
      bus_err       = 1'b0;
      if (rst_n) begin
         bus_err = timeout;
         md_done = (state == MD_BUSY) && (md_cnt == '0) && !mem_stall;
         if (mem_stall) begin
            hold_pc_n     = 1'b0;
            hold_if_id_n  = 1'b0;
            hold_id_ex_n  = 1'b0;
            hold_ex_mem_n = 1'b0;
            hold_mem_wb_n = 1'b0;
         end else if (md_stall) begin
            hold_pc_n    = 1'b0;
            hold_if_id_n = 1'b0;
            hold_id_ex_n = 1'b0;
            flush_ex_mem = 1'b1;
         end else if (jump_en_ex) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end else if (load_use) begin
            hold_pc_n    = 1'b0;
            hold_if_id_n = 1'b0;
            flush_id_ex  = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         md_cnt   <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         md_cnt   <= md_cnt_nx;
         wait_cnt <= mem_stall ? wait_cnt + WW'(1) : '0;
      end
   end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
   localparam int         MDC   = 4;
   localparam int         MTO   = 8;
   localparam logic [2:0] LNOPE = 3'd0;
   localparam logic [2:0] LB    = 3'd1;
   localparam logic [9:0] IDLE  = 10'b11111_00000;
   localparam logic [9:0] FROZE = 10'b00000_00000;
   localparam logic [9:0] MDST  = 10'b00011_00100;
   localparam logic [9:0] DONE  = 10'b11111_00010;
   localparam logic [9:0] LUST  = 10'b00111_01000;
   localparam logic [9:0] JMP   = 10'b11111_11000;
   localparam logic [9:0] BERR  = 10'b11111_00001;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] rs1_addr_id, rs2_addr_id, addr_rd_ex;
   logic       rs1_use_id, rs2_use_id, reg_wr_en_ex, md_start_ex, jump_en_ex, mem_req_mem, mem_ack_mem;
   logic [2:0] load_code_ex;
   logic hold_pc_n, hold_if_id_n, hold_id_ex_n, hold_ex_mem_n, hold_mem_wb_n;
   logic flush_if_id, flush_id_ex, flush_ex_mem, md_done, bus_err;
   int   checks = 0;
   int   failures = 0;
   bit   m_busy;
   int   m_left, m_wait;
   logic [9:0] act, exp_v;
   pipe_ctrl #(.MD_CYCLES(MDC), .MEM_TIMEOUT(MTO), .LOAD_NOPE(LNOPE)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr_id(rs1_addr_id), .rs1_use_id(rs1_use_id),
      .rs2_addr_id(rs2_addr_id), .rs2_use_id(rs2_use_id),
      .load_code_ex(load_code_ex), .addr_rd_ex(addr_rd_ex), .reg_wr_en_ex(reg_wr_en_ex),
      .md_start_ex(md_start_ex), .jump_en_ex(jump_en_ex),
      .mem_req_mem(mem_req_mem), .mem_ack_mem(mem_ack_mem),
      .hold_pc_n(hold_pc_n), .hold_if_id_n(hold_if_id_n), .hold_id_ex_n(hold_id_ex_n),
      .hold_ex_mem_n(hold_ex_mem_n), .hold_mem_wb_n(hold_mem_wb_n),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
      .md_done(md_done), .bus_err(bus_err)
   );
   always #5 clk = ~clk;
   task automatic clear_in();
      rs1_addr_id = 5'd0; rs2_addr_id = 5'd0; addr_rd_ex = 5'd0;
      rs1_use_id = 1'b0; rs2_use_id = 1'b0; reg_wr_en_ex = 1'b0;
      load_code_ex = LNOPE; md_start_ex = 1'b0; jump_en_ex = 1'b0;
      mem_req_mem = 1'b0; mem_ack_mem = 1'b0;
   endtask
   function automatic logic [9:0] model_out();
      bit to, ms, front, lu, done;
      if (!rst_n) return IDLE;
      to    = mem_req_mem && !mem_ack_mem && (m_wait == MTO - 1);
      ms    = mem_req_mem && !mem_ack_mem && !to;
      front = m_busy ? (m_left > 1) : md_start_ex;
      done  = m_busy && (m_left <= 1) && !ms;
      lu    = (load_code_ex != LNOPE) && reg_wr_en_ex && (addr_rd_ex != 0) &&
              ((rs1_use_id && rs1_addr_id == addr_rd_ex) || (rs2_use_id && rs2_addr_id == addr_rd_ex));
      if (ms) return {FROZE[9:2], done, to};
      if (front) return {MDST[9:2], done, to};
      if (jump_en_ex) return {JMP[9:2], done, to};
      if (lu) return {LUST[9:2], done, to};
      return {IDLE[9:2], done, to};
   endfunction
   function automatic void model_update();
      bit to, ms;
      if (!rst_n) begin
         m_busy = 0; m_left = 0; m_wait = 0;
         return;
      end
      to = mem_req_mem && !mem_ack_mem && (m_wait == MTO - 1);
      ms = mem_req_mem && !mem_ack_mem && !to;
      m_wait = ms ? m_wait + 1 : 0;
      if (!m_busy) begin
         if (md_start_ex && !ms) begin
            m_busy = 1;
            m_left = MDC - 1;
         end
      end else if (m_left > 1) m_left--;
      else if (!ms) m_busy = 0;
   endfunction
   task automatic cycle(input string name);
      #1;
      exp_v = model_out();
      act = {hold_pc_n, hold_if_id_n, hold_id_ex_n, hold_ex_mem_n, hold_mem_wb_n,
             flush_if_id, flush_id_ex, flush_ex_mem, md_done, bus_err};
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp_v);
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask
   task automatic test_reset();
      clear_in();
      rst_n = 1'b0; md_start_ex = 1'b1; mem_req_mem = 1'b1; jump_en_ex = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle("reset");
         checks++;
         if (act !== IDLE) begin failures++; $display("FAIL reset_idle got=%b want=%b", act, IDLE); end
      end
      clear_in();
      rst_n = 1'b1;
      cycle("post_reset");
   endtask
   task automatic test_load_use();
      logic [9:0] want;
      for (int i = 0; i < 4; i++) begin
         clear_in();
         load_code_ex = LB; reg_wr_en_ex = 1'b1;
         addr_rd_ex = (i == 1) ? 5'd0 : 5'd5;
         rs1_addr_id = (i == 1) ? 5'd0 : 5'd5;
         rs1_use_id = (i != 2) && (i != 3);
         rs2_addr_id = 5'd5; rs2_use_id = (i == 3);
         want = (i == 1 || i == 2) ? IDLE : LUST;
         cycle("load_use");
         checks++;
         if (act !== want) begin failures++; $display("FAIL load_use_%0d got=%b want=%b", i, act, want); end
      end
      clear_in();
      cycle("load_use_after");
   endtask
   task automatic test_md();
      clear_in();
      md_start_ex = 1'b1;
      for (int i = 0; i < MDC; i++) begin
         cycle("md");
         checks++;
         if (act !== ((i < MDC - 1) ? MDST : DONE)) begin
            failures++; $display("FAIL md_c%0d got=%b", i, act);
         end
      end
      clear_in();
      cycle("md_after");
   endtask
   task automatic test_mem_wait();
      clear_in();
      mem_req_mem = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_ack_mem = (i == 3);
         cycle("mem_ack");
         checks++;
         if (act !== ((i < 3) ? FROZE : IDLE)) begin failures++; $display("FAIL mem_ack_c%0d got=%b", i, act); end
      end
      clear_in();
      cycle("mem_gap");
      mem_req_mem = 1'b1;
      for (int i = 0; i < MTO; i++) begin
         cycle("mem_timeout");
         checks++;
         if (act !== ((i < MTO - 1) ? FROZE : BERR)) begin failures++; $display("FAIL mem_to_c%0d got=%b", i, act); end
      end
      clear_in();
      cycle("mem_after");
   endtask
   task automatic test_jump_load();
      clear_in();
      jump_en_ex = 1'b1; load_code_ex = LB; reg_wr_en_ex = 1'b1;
      addr_rd_ex = 5'd7; rs2_addr_id = 5'd7; rs2_use_id = 1'b1;
      cycle("jump_load");
      checks++;
      if (act !== JMP) begin failures++; $display("FAIL jump_load got=%b want=%b", act, JMP); end
      clear_in();
      cycle("jump_after");
   endtask
   task automatic test_md_mem();
      clear_in();
      md_start_ex = 1'b1;
      for (int i = 0; i < 7; i++) begin
         mem_req_mem = (i >= 1 && i <= 5);
         cycle("md_mem");
         checks++;
         if (act !== ((i == 0) ? MDST : (i <= 5) ? FROZE : DONE)) begin
            failures++; $display("FAIL md_mem_c%0d got=%b", i, act);
         end
      end
      clear_in();
      cycle("md_mem_after");
   endtask
   task automatic test_reset_mid_md();
      clear_in();
      md_start_ex = 1'b1;
      cycle("rst_md_c0");
      rst_n = 1'b0;
      cycle("rst_md_c1");
      rst_n = 1'b1; md_start_ex = 1'b0;
      cycle("rst_md_c2");
      checks++;
      if (act !== IDLE) begin failures++; $display("FAIL rst_md_idle got=%b want=%b", act, IDLE); end
      md_start_ex = 1'b1;
      for (int i = 0; i < MDC; i++) begin
         cycle("rst_md_restart");
         checks++;
         if (act !== ((i < MDC - 1) ? MDST : DONE)) begin
            failures++; $display("FAIL rst_md_restart_c%0d got=%b", i, act);
         end
      end
      clear_in();
      cycle("rst_md_after");
   endtask
   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst_n        = ($urandom_range(63) != 0);
         rs1_addr_id  = 5'($urandom_range(3));
         rs2_addr_id  = 5'($urandom_range(3));
         addr_rd_ex   = 5'($urandom_range(3));
         rs1_use_id   = 1'($urandom_range(1));
         rs2_use_id   = 1'($urandom_range(1));
         reg_wr_en_ex = 1'($urandom_range(1));
         load_code_ex = 3'($urandom_range(3));
         md_start_ex  = ($urandom_range(5) == 0);
         jump_en_ex   = ($urandom_range(5) == 0);
         mem_req_mem  = ($urandom_range(3) != 0);
         mem_ack_mem  = ($urandom_range(7) == 0);
         cycle("random");
      end
      rst_n = 1'b1;
      clear_in();
   endtask
   initial begin
      clear_in();
      m_busy = 0; m_left = 0; m_wait = 0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_md();
      test_mem_wait();
      test_jump_load();
      test_md_mem();
      test_reset_mid_md();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
